// File: rtl/tron_pkg.sv
// Shared types and default timing constants for the two-player trace game sequencer.
package tron_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    COUNTDOWN = 3'd2,
    PLAY      = 3'd3,
    ROUND_END = 3'd4,
    GAME_OVER = 3'd5
  } game_state_t;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    P1   = 2'b01,
    P2   = 2'b10,
    DRAW = 2'b11
  } winner_t;

  localparam int DEF_FRAMES_PER_STEP  = 4;
  localparam int DEF_FRAMES_PER_SEC   = 60;
  localparam int DEF_COUNTDOWN_SECS   = 3;
  localparam int DEF_ROUND_END_FRAMES = 120;
  localparam int DEF_WIN_SCORE        = 5;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tron_game_ctrl_frame_counter.sv
// Frame-tick counter shared by every game state; done fires on the limit-th tick and the
// count returns to 0 in the same edge.
module frame_counter #(
  parameter int MAX = 120,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // limit selects the terminal count for the current state, never above MAX, so no wrap.
  assign done = tick && !clr && (count == limit - W'(1));

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr || done) begin
      count <= '0;
    end else if (tick) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tron_game_ctrl.sv
// Round sequencer for the trace game: clear, countdown, paced play, crash hold, scoring
// and match end, all in the pixel clock domain.
module tron_game_ctrl
  import tron_pkg::*;
#(
  parameter int FRAMES_PER_STEP  = DEF_FRAMES_PER_STEP,
  parameter int FRAMES_PER_SEC   = DEF_FRAMES_PER_SEC,
  parameter int COUNTDOWN_SECS   = DEF_COUNTDOWN_SECS,
  parameter int ROUND_END_FRAMES = DEF_ROUND_END_FRAMES,
  parameter int WIN_SCORE        = DEF_WIN_SCORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       crash_p1,
  input  logic       crash_p2,
  input  logic       clear_busy,
  output logic       clear_trace,
  output logic       step_en,
  output logic       round_active,
  output logic [2:0] state,
  output logic [3:0] countdown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [1:0] round_winner
);

  localparam int FC_MAX = max3(FRAMES_PER_STEP, FRAMES_PER_SEC, ROUND_END_FRAMES);
  localparam int FC_W   = $clog2(FC_MAX + 1);
  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [3:0] CD  = 4'(COUNTDOWN_SECS);

  game_state_t       state_q;
  winner_t           winner_q;
  logic              start_q;
  logic              start_rise;
  logic              crash_any;
  logic [1:0]        clr_wait;
  logic              fc_clr;
  logic              fc_done;
  logic [FC_W-1:0]   fc_limit;

  assign start_rise   = start && !start_q;
  assign crash_any    = crash_p1 || crash_p2;
  assign state        = state_q;
  assign round_winner = winner_q;
  assign round_active = (state_q == PLAY);

  // Held clear where ticks are ignored; a crash abandons the partial step count. The other
  // exits happen on done, which already returns the count to 0.
  assign fc_clr = (state_q == IDLE) || (state_q == CLEAR) || (state_q == GAME_OVER) ||
                  ((state_q == PLAY) && crash_any);

  // NOTE: every variable written in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    fc_limit = FC_W'(ROUND_END_FRAMES);
    case (state_q)
      COUNTDOWN: fc_limit = FC_W'(FRAMES_PER_SEC);
      PLAY:      fc_limit = FC_W'(FRAMES_PER_STEP);
      default:   ;
    endcase
  end

  frame_counter #(.MAX(FC_MAX)) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (fc_clr),
    .tick  (frame_tick),
    .limit (fc_limit),
    .done  (fc_done)
  );

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s < WIN) ? s + 4'd1 : s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      winner_q    <= NONE;
      start_q     <= 1'b0;
      clr_wait    <= 2'd0;
      clear_trace <= 1'b0;
      step_en     <= 1'b0;
      countdown   <= 4'd0;
      score_p1    <= 4'd0;
      score_p2    <= 4'd0;
    end else begin
      start_q     <= start;
      clear_trace <= 1'b0;
      step_en     <= 1'b0;

      case (state_q)
        IDLE, GAME_OVER: begin
          if (start_rise) begin
            score_p1    <= 4'd0;
            score_p2    <= 4'd0;
            winner_q    <= NONE;
            clr_wait    <= 2'd0;
            clear_trace <= 1'b1;
            state_q     <= CLEAR;
          end
        end

        CLEAR: begin
          // Give the datapath two cycles to raise clear_busy before trusting it.
          if (clr_wait != 2'd2) begin
            clr_wait <= clr_wait + 2'd1;
          end else if (!clear_busy) begin
            countdown <= CD;
            state_q   <= COUNTDOWN;
          end
        end

        COUNTDOWN: begin
          if (fc_done) begin
            if (countdown == 4'd1) begin
              countdown <= 4'd0;
              state_q   <= PLAY;
            end else begin
              countdown <= countdown - 4'd1;
            end
          end
        end

        PLAY: begin
          if (crash_any) begin
            state_q <= ROUND_END;
            case ({crash_p2, crash_p1})
              2'b01: begin
                score_p2 <= sat_inc(score_p2);
                winner_q <= P2;
              end
              2'b10: begin
                score_p1 <= sat_inc(score_p1);
                winner_q <= P1;
              end
              default: winner_q <= DRAW;
            endcase
          end else begin
            step_en <= fc_done;
          end
        end

        ROUND_END: begin
          if (fc_done) begin
            if ((score_p1 == WIN) || (score_p2 == WIN)) begin
              state_q <= GAME_OVER;
            end else begin
              winner_q    <= NONE;
              clr_wait    <= 2'd0;
              clear_trace <= 1'b1;
              state_q     <= CLEAR;
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tron_game_ctrl.sv
// Self-checking bench for tron_game_ctrl: directed scenarios with randomized timing, every
// cycle compared against a rule-level model of the game.
module tb_tron_game_ctrl;
  import tron_pkg::*;

  localparam int FPSTEP = 2;
  localparam int FPS    = 3;
  localparam int CD     = 2;
  localparam int REF    = 4;
  localparam int WIN    = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic       crash_p1;
  logic       crash_p2;
  logic       clear_busy;
  logic       clear_trace;
  logic       step_en;
  logic       round_active;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] round_winner;

  always #5 clk = ~clk;

  tron_game_ctrl #(
    .FRAMES_PER_STEP  (FPSTEP),
    .FRAMES_PER_SEC   (FPS),
    .COUNTDOWN_SECS   (CD),
    .ROUND_END_FRAMES (REF),
    .WIN_SCORE        (WIN)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_tick   (frame_tick),
    .crash_p1     (crash_p1),
    .crash_p2     (crash_p2),
    .clear_busy   (clear_busy),
    .clear_trace  (clear_trace),
    .step_en      (step_en),
    .round_active (round_active),
    .state        (state),
    .countdown    (countdown),
    .score_p1     (score_p1),
    .score_p2     (score_p2),
    .round_winner (round_winner)
  );

  int n_compared = 0;
  int n_mismatch = 0;
  int cyc        = 0;
  int busy_left  = 0;
  int force_busy = 0;

  // Reference model: phase plus counts of frames and cycles spent in it.
  game_state_t m_state;
  int          m_ticks;
  int          m_cyc;
  int          m_s1;
  int          m_s2;
  logic [1:0]  m_winner;
  logic        m_start_prev;
  logic        exp_clear;
  logic        exp_step;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatch++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_ticks = 0; m_cyc = 0; m_s1 = 0; m_s2 = 0;
    m_winner = 2'b00; m_start_prev = 1'b0; exp_clear = 1'b0; exp_step = 1'b0;
  endtask

  task automatic model_enter_clear();
    m_state = CLEAR; exp_clear = 1'b1; m_winner = 2'b00; m_cyc = 0;
  endtask

  // Applies the rules to the inputs sampled at this clock edge.
  task automatic model_clock();
    logic rise;
    rise = start && !m_start_prev;
    m_start_prev = start;
    exp_clear = 1'b0;
    exp_step  = 1'b0;
    case (m_state)
      IDLE, GAME_OVER: if (rise) begin m_s1 = 0; m_s2 = 0; model_enter_clear(); end
      CLEAR: begin
        if (m_cyc >= 2 && !clear_busy) begin m_state = COUNTDOWN; m_ticks = 0; end
        m_cyc++;
      end
      COUNTDOWN: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == CD * FPS) begin m_state = PLAY; m_ticks = 0; end
      end
      PLAY: begin
        if (crash_p1 || crash_p2) begin
          if (crash_p1 && crash_p2) m_winner = 2'b11;
          else if (crash_p1) begin m_winner = 2'b10; if (m_s2 < WIN) m_s2++; end
          else begin m_winner = 2'b01; if (m_s1 < WIN) m_s1++; end
          m_state = ROUND_END; m_ticks = 0;
        end else if (frame_tick) begin
          m_ticks++;
          exp_step = (m_ticks % FPSTEP == 0);
        end
      end
      ROUND_END: if (frame_tick) begin
        m_ticks++;
        if (m_ticks == REF) begin
          if (m_s1 == WIN || m_s2 == WIN) m_state = GAME_OVER;
          else model_enter_clear();
        end
      end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    logic [3:0] exp_cd;
    exp_cd = (m_state == COUNTDOWN) ? 4'(CD - m_ticks / FPS) : 4'd0;
    check("state", 4'(state), 4'(m_state));
    check("countdown", countdown, exp_cd);
    check("score_p1", score_p1, 4'(m_s1));
    check("score_p2", score_p2, 4'(m_s2));
    check("round_winner", 4'(round_winner), 4'(m_winner));
    check("clear_trace", 4'(clear_trace), 4'(exp_clear));
    check("step_en", 4'(step_en), 4'(exp_step));
    check("round_active", 4'(round_active), 4'(m_state == PLAY));
  endtask

  // One clock: drive bench-owned inputs, advance DUT and model, compare on the falling edge.
  task automatic tick_cycle();
    frame_tick = (cyc % 10 == 9);
    clear_busy = (busy_left > 0);
    @(posedge clk);
    model_clock();
    cyc++;
    if (busy_left > 0) busy_left--;
    if (exp_clear) begin
      busy_left  = (force_busy > 0) ? force_busy : $urandom_range(0, 5);
      force_busy = 0;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic wait_state(input game_state_t s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin tick_cycle(); n++; end
    check(tag, 4'(state), 4'(s));
  endtask

  task automatic crash_round(input logic p1, input logic p2, input bit due, input string tag);
    int n = 0;
    wait_state(PLAY, 400, {tag, "_play"});
    if (due) begin
      while (!((cyc % 10 == 9) && ((m_ticks + 1) % FPSTEP == 0)) && n < 100) begin
        tick_cycle(); n++;
      end
    end else begin
      run($urandom_range(0, 40));
    end
    crash_p1 = p1; crash_p2 = p2;
    tick_cycle();
    crash_p1 = 1'b0; crash_p2 = 1'b0;
    check({tag, "_round_end"}, 4'(state), 4'(ROUND_END));
  endtask

  // Reset is raised between clock edges and checked before the next rising edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    busy_left = 0;
    check({tag, "_state"}, 4'(state), 4'(IDLE));
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    int n;
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
    crash_p1 = 1'b0; crash_p2 = 1'b0; clear_busy = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    reset = 1'b0;

    // Serve held for 5 cycles, clear busy for 6 cycles after the pulse.
    force_busy = 6;
    start = 1'b1;
    run(5);
    start = 1'b0;
    wait_state(COUNTDOWN, 20, "s1_countdown");
    check("s1_cd_value", countdown, 4'd2);

    // Countdown into play, several paced steps.
    wait_state(PLAY, 100, "s2_play");
    run(45);

    // Player 1 crashes.
    crash_round(1'b1, 1'b0, 1'b0, "s3");
    check("s3_score_p2", score_p2, 4'd1);
    check("s3_winner", 4'(round_winner), 4'd2);
    wait_state(CLEAR, 60, "s3_clear");
    check("s3_clear_pulse", 4'(clear_trace), 4'd1);
    check("s3_winner_cleared", 4'(round_winner), 4'd0);

    // Both crash on the tick that completes a step.
    crash_round(1'b1, 1'b1, 1'b1, "s4");
    check("s4_no_step", 4'(step_en), 4'd0);
    check("s4_draw", 4'(round_winner), 4'd3);
    check("s4_score_p2", score_p2, 4'd1);

    // Two player-2 crashes end the match for player 1.
    crash_round(1'b0, 1'b1, 1'b0, "s5a");
    crash_round(1'b0, 1'b1, 1'b0, "s5b");
    wait_state(GAME_OVER, 60, "s5_game_over");
    check("s5_score_p1", score_p1, 4'd2);
    run($urandom_range(0, 15));
    start = 1'b1;
    tick_cycle();
    check("s5_restart", 4'(state), 4'(CLEAR));
    check("s5_scores_zero", score_p1 | score_p2, 4'd0);
    wait_state(PLAY, 100, "s5_play");
    run(20);
    repeat (6) begin start = ~start; run(3); end
    start = 1'b0;
    check("s5_start_ignored", 4'(state), 4'(PLAY));

    // Asynchronous reset mid-play and mid-countdown.
    async_reset("s6_play");
    start = 1'b1;
    tick_cycle();
    start = 1'b0;
    wait_state(COUNTDOWN, 20, "s6_countdown");
    run($urandom_range(1, 30));
    async_reset("s6_cd");

    // Randomized full matches.
    for (int r = 0; r < 3; r++) begin
      start = 1'b1;
      tick_cycle();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
        c = $urandom_range(1, 3);
        crash_round(c[0], c[1], ($urandom_range(0, 1) == 1), "rnd");
        n = 0;
        while (m_state == ROUND_END && n < 100) begin tick_cycle(); n++; end
        if (m_state == GAME_OVER) break;
      end
      wait_state(GAME_OVER, 10, "rnd_game_over");
      run($urandom_range(0, 10));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
